axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI4 read channel between the instruction-fetch refill and the data-load refill requesters.
- Sequences one outstanding burst at a time through an IDLE/AR/R state machine.
- Steers returning beats to the owning requester and drops the instruction burst's data after a pipeline flush.
- Sits between the cache miss logic and the AXI master interface; `busy` feeds the pipeline controller's cache stall request.

Parameters:
- INST_ID, 4'd0, ARID driven for instruction bursts
- DATA_ID, 4'd1, ARID driven for data bursts

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush from the controller; affects only instruction traffic
- inst_req  in  1  instruction refill request; held until inst_grant
- inst_addr  in  32  burst start address
- inst_len  in  8  beats minus one
- inst_grant  out  1  one-cycle pulse when the request is latched
- inst_rvalid  out  1  beat valid to the instruction requester
- inst_rdata  out  32  beat data
- inst_rlast  out  1  final beat, derived from the beat counter
- data_req, data_addr, data_len, data_grant, data_rvalid, data_rdata, data_rlast: same widths and meaning, for the data side
- arid  out  4; araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1
- rid  in  4; rdata  in  32; rlast  in  1; rvalid  in  1; rready  out  1
- busy  out  1  high whenever state != IDLE
- proto_err  out  1  sticky; set on rlast/counter mismatch or rid mismatch

Behaviour:
- Reset values:
  - state=IDLE
  - arvalid=0, rready=0, arid/araddr/arlen=0
  - arsize=3'b010 and arburst=2'b01 (INCR), both constant
  - all grant, rvalid and rlast outputs = 0
  - proto_err=0, drop=0, beat_cnt=0
- Reset mid-burst: abandons the transaction immediately; no beats are forwarded afterwards.
- IDLE:
  - A request is eligible when req=1; inst_req is masked in any cycle where flush=1.
  - Both eligible: data wins.
  - On a win: latch owner, id, addr and len into AR registers; pulse that side's grant for 1 cycle; next state AR.
- AR:
  - arvalid=1; arid/araddr/arlen held stable until arready.
  - On arvalid&arready: arvalid=0, rready=1, beat_cnt=0, next state R.
  - Minimum request-to-arvalid latency is 1 cycle.
- R:
  - Each rvalid&rready beat is forwarded combinationally in the same cycle: owner_rvalid=1, owner_rdata=rdata.
  - owner_rlast=1 when beat_cnt==latched len.
  - beat_cnt increments per beat, 8-bit.
  - Counter-final beat: rready drops next cycle and state returns to IDLE, whether or not rlast is set.
  - rlast seen before counter-final, or counter-final without rlast: set proto_err. Beats with rid != latched id also set proto_err; they are still consumed and forwarded.
  - The non-owner's rvalid is always 0.
- IDLE re-entry:
  - At least 1 IDLE cycle between bursts.
  - A requester whose req stays high after its burst completes is treated as a new request.
- Flush:
  - flush=1 while owner=inst in AR or R sets drop.
  - While drop=1: inst_rvalid and inst_rlast are forced to 0, but beats are still accepted (rready stays 1) until the burst completes. This is required because AXI has no read abort.
  - drop clears on return to IDLE.
  - flush never affects a data burst.
- busy=1 in AR and R.
- No new grant while busy.

Optional Feature:
- Macro: AXI_RD_RR_ARB_EN
- Defined: round-robin arbitration.
  - A last_owner register updates on each grant; reset value = data.
  - On simultaneous eligible requests, the side not equal to last_owner wins, so the first conflict after reset grants inst.
- Undefined: fixed data-over-inst priority; no last_owner register.

Test Plan:
- rst then idle → arvalid=0, rready=0, busy=0, proto_err=0, no grants.
- inst_req, addr 0x1FC0_0000, len 7; arready after 2 cycles; 8 R beats with rlast on beat 8, rid 0 → inst_grant pulse; arid=0, araddr=0x1FC0_0000, arlen=7; 8 inst_rvalid beats; inst_rlast on 8th; busy clears.
- inst_req and data_req asserted in the same cycle (fixed priority) → data granted first (arid=1); inst granted after data burst + 1 IDLE cycle. With AXI_RD_RR_ARB_EN from reset → inst first, then data.
- inst burst len 3; flush pulse after beat 1 → beat 1 forwarded; beats 2-4 accepted with rready=1 but inst_rvalid=0; state IDLE after beat 4.
- data burst len 3 with rlast asserted on beat 3 → proto_err=1 and sticky; data_rlast on beat 4; return to IDLE after beat 4.
- rst asserted in R mid-burst → next cycle rready=0, state IDLE, no further *_rvalid.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address/data channel bundle between the read arbiter (master)
// and the bus fabric (slave).
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between instruction and data refills, one burst at a time.
// Define AXI_RD_RR_ARB_EN for round-robin arbitration; otherwise data has fixed priority.
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    inst_req,
  input  logic [31:0]             inst_addr,
  input  logic [7:0]              inst_len,
  output logic                    inst_grant,
  output logic                    inst_rvalid,
  output logic [31:0]             inst_rdata,
  output logic                    inst_rlast,
  input  logic                    data_req,
  input  logic [31:0]             data_addr,
  input  logic [7:0]              data_len,
  output logic                    data_grant,
  output logic                    data_rvalid,
  output logic [31:0]             data_rdata,
  output logic                    data_rlast,
  axi_rd_arbiter_if.master        axi,
  output logic                    busy,
  output logic                    proto_err
);

  // state  | meaning
  // S_IDLE | no burst outstanding; arbitrate and latch the winner
  // S_AR   | address phase, arvalid held until arready
  // S_R    | data phase, beats steered to the owner until counter-final
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;        // 1 = data side owns the burst
  logic [3:0]  ar_id, ar_id_nxt;
  logic [31:0] ar_addr, ar_addr_nxt;
  logic [7:0]  ar_len, ar_len_nxt;
  logic [7:0]  beat_cnt, beat_cnt_nxt;
  logic        drop, drop_nxt;
  logic        perr, perr_nxt;

  logic        inst_elig;
  logic        data_elig;
  logic        pick_data;
  logic        beat;
  logic        cnt_final;

`ifdef AXI_RD_RR_ARB_EN
  logic        last_owner, last_owner_nxt;

  // On conflict the side that did not win last time goes first.
  assign pick_data = data_elig & (~inst_elig | ~last_owner);
`else
  assign pick_data = data_elig;
`endif

  assign inst_elig = inst_req & ~flush;
  assign data_elig = data_req;

  assign beat      = axi.rvalid & axi.rready;
  assign cnt_final = (beat_cnt == ar_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      ar_id      <= '0;
      ar_addr    <= '0;
      ar_len     <= '0;
      beat_cnt   <= '0;
      drop       <= 1'b0;
      perr       <= 1'b0;
`ifdef AXI_RD_RR_ARB_EN
      last_owner <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      ar_id      <= ar_id_nxt;
      ar_addr    <= ar_addr_nxt;
      ar_len     <= ar_len_nxt;
      beat_cnt   <= beat_cnt_nxt;
      drop       <= drop_nxt;
      perr       <= perr_nxt;
`ifdef AXI_RD_RR_ARB_EN
      last_owner <= last_owner_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    ar_id_nxt      = ar_id;
    ar_addr_nxt    = ar_addr;
    ar_len_nxt     = ar_len;
    beat_cnt_nxt   = beat_cnt;
    drop_nxt       = drop;
    perr_nxt       = perr;
    inst_grant     = 1'b0;
    data_grant     = 1'b0;
`ifdef AXI_RD_RR_ARB_EN
    last_owner_nxt = last_owner;
`endif

    case (state)
      S_IDLE: begin
        drop_nxt = 1'b0;
        if (inst_elig | data_elig) begin
          owner_nxt   = pick_data;
          ar_id_nxt   = pick_data ? DATA_ID : INST_ID;
          ar_addr_nxt = pick_data ? data_addr : inst_addr;
          ar_len_nxt  = pick_data ? data_len : inst_len;
          inst_grant  = ~pick_data;
          data_grant  = pick_data;
          state_nxt   = S_AR;
`ifdef AXI_RD_RR_ARB_EN
          last_owner_nxt = pick_data;
`endif
        end
      end

      S_AR: begin
        if (flush & ~owner) begin
          drop_nxt = 1'b1;
        end
        if (axi.arready) begin
          beat_cnt_nxt = '0;
          state_nxt    = S_R;
        end
      end

      S_R: begin
        if (flush & ~owner) begin
          drop_nxt = 1'b1;
        end
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          if ((axi.rlast != cnt_final) || (axi.rid != ar_id)) begin
            perr_nxt = 1'b1;
          end
          // Burst length is owned by our counter; rlast is only cross-checked.
          if (cnt_final) begin
            beat_cnt_nxt = '0;
            drop_nxt     = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign axi.arvalid = (state == S_AR);
  assign axi.rready  = (state == S_R);
  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_len;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;

  // A flushed instruction burst still drains on the bus but is hidden from the requester.
  assign inst_rvalid = beat & ~owner & ~drop;
  assign inst_rlast  = inst_rvalid & cnt_final;
  assign inst_rdata  = axi.rdata;
  assign data_rvalid = beat & owner;
  assign data_rlast  = data_rvalid & cnt_final;
  assign data_rdata  = axi.rdata;

  assign busy      = (state != S_IDLE);
  assign proto_err = perr;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed cases plus randomized bursts
// checked against a transaction-level model of grants, beats, drops and protocol errors.
module tb_axi_rd_arbiter;
  localparam logic [3:0] INST_ID   = 4'd0;
  localparam logic [3:0] DATA_ID   = 4'd1;
  localparam bit         SIDE_INST = 1'b0;
  localparam bit         SIDE_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [7:0]  inst_len, data_len;
  logic        inst_grant, inst_rvalid, inst_rlast;
  logic        data_grant, data_rvalid, data_rlast;
  logic [31:0] inst_rdata, data_rdata;
  logic        busy, proto_err;

  axi_rd_arbiter_if axi();

  axi_rd_arbiter #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_len   (inst_len),
    .inst_grant (inst_grant),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .inst_rlast (inst_rlast),
    .data_req   (data_req),
    .data_addr  (data_addr),
    .data_len   (data_len),
    .data_grant (data_grant),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .data_rlast (data_rlast),
    .axi        (axi),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit m_last_owner;   // model of which side won the previous grant
  bit m_perr;         // model of the sticky protocol error

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_winner();
`ifdef AXI_RD_RR_ARB_EN
    return ~m_last_owner;
`else
    return SIDE_DATA;
`endif
  endfunction

  task automatic expect_grant(input bit side, input int exp_wait);
    bit got_it;
    got_it = 1'b0;
    for (int c = 0; c < 20 && !got_it; c++) begin
      @(negedge clk);
      if (inst_grant || data_grant) begin
        got_it = 1'b1;
        chk("grant_side", data_grant, side);
        chk("grant_onehot", inst_grant & data_grant, 1'b0);
        chk("grant_in_idle", busy, 1'b0);
        if (exp_wait >= 0) chk("grant_wait", c, exp_wait);
      end
      step();
    end
    chk("grant_seen", got_it, 1'b1);
    if (side == SIDE_INST) inst_req = 1'b0;
    else                   data_req = 1'b0;
    m_last_owner = side;
  endtask

  // flush_at: -1 none, -2 during address phase, k>=0 in a gap after beat k
  task automatic serve(input bit side, input logic [31:0] addr, input logic [7:0] len,
                       input int ar_delay, input int flush_at,
                       input bit bad_last, input bit bad_id);
    bit          dropped;
    bit          vis;
    bit          lst;
    logic [3:0]  id;
    logic [31:0] d;
    dropped = 1'b0;
    id      = side ? DATA_ID : INST_ID;
    for (int k = 0; k <= ar_delay; k++) begin
      axi.arready = (k == ar_delay);
      if (flush_at == -2 && k == 0) flush = 1'b1;
      @(negedge clk);
      chk("arvalid", axi.arvalid, 1'b1);
      chk("arid", axi.arid, id);
      chk("araddr", axi.araddr, addr);
      chk("arlen", axi.arlen, len);
      chk("ar_rready", axi.rready, 1'b0);
      chk("ar_busy", busy, 1'b1);
      step();
      flush = 1'b0;
    end
    axi.arready = 1'b0;
    if (flush_at == -2 && side == SIDE_INST) dropped = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (flush_at >= 0 && i == flush_at + 1) begin
        flush = 1'b1;
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("flush_rready", axi.rready, 1'b1);
        step();
        flush = 1'b0;
        if (side == SIDE_INST) dropped = 1'b1;
      end
      repeat ($urandom_range(0, 1)) begin
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("gap_rvalid", inst_rvalid | data_rvalid, 1'b0);
        step();
      end
      d   = $urandom;
      lst = bad_last ? (i == int'(len) - 1) : (i == int'(len));
      axi.rvalid = 1'b1;
      axi.rdata  = d;
      axi.rlast  = lst;
      axi.rid    = (bad_id && i == 0) ? ~id : id;
      vis = (side == SIDE_DATA) || !dropped;
      if ((lst != (i == int'(len))) || (axi.rid != id)) m_perr = 1'b1;
      @(negedge clk);
      chk("rready", axi.rready, 1'b1);
      chk("inst_rvalid", inst_rvalid, (side == SIDE_INST) && vis);
      chk("data_rvalid", data_rvalid, side == SIDE_DATA);
      chk("inst_rlast", inst_rlast, (side == SIDE_INST) && vis && (i == int'(len)));
      chk("data_rlast", data_rlast, (side == SIDE_DATA) && (i == int'(len)));
      if (vis) chk("rdata", side ? data_rdata : inst_rdata, d);
      step();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    #1;
    chk("end_busy", busy, 1'b0);
    chk("end_rready", axi.rready, 1'b0);
    chk("end_arvalid", axi.arvalid, 1'b0);
    chk("proto_err", proto_err, m_perr);
  endtask

  function automatic int rand_flush(input int l);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return -2;
    if (r == 1 && l > 0) return $urandom_range(0, l - 1);
    return -1;
  endfunction

  task automatic random_phase(input int n_iter);
    bit          both;
    bit          s;
    bit          w;
    logic [31:0] ai, ad;
    logic [7:0]  li, ld;
    for (int n = 0; n < n_iter; n++) begin
      both = ($urandom_range(0, 2) == 0);
      s    = $urandom_range(0, 1);
      ai   = $urandom & 32'hFFFF_FFFC;
      ad   = $urandom & 32'hFFFF_FFFC;
      li   = 8'($urandom_range(0, 7));
      ld   = 8'($urandom_range(0, 7));
      inst_addr = ai; inst_len = li;
      data_addr = ad; data_len = ld;
      if (both) begin
        inst_req = 1'b1;
        data_req = 1'b1;
        w = exp_winner();
        expect_grant(w, 0);
        serve(w, w ? ad : ai, w ? ld : li, $urandom_range(0, 3),
              rand_flush(w ? int'(ld) : int'(li)), 1'b0, 1'b0);
        expect_grant(~w, 0);
        serve(~w, w ? ai : ad, w ? li : ld, $urandom_range(0, 3),
              rand_flush(w ? int'(li) : int'(ld)), 1'b0, 1'b0);
      end else begin
        if (s) data_req = 1'b1;
        else   inst_req = 1'b1;
        expect_grant(s, 0);
        serve(s, s ? ad : ai, s ? ld : li, $urandom_range(0, 3),
              rand_flush(s ? int'(ld) : int'(li)), 1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0; inst_len = '0;
    data_req = 1'b0; data_addr = '0; data_len = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    m_last_owner = SIDE_DATA;
    m_perr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_grants", {inst_grant, data_grant}, 2'b00);
    chk("rst_rvalids", {inst_rvalid, data_rvalid, inst_rlast, data_rlast}, 4'b0000);
    chk("rst_ar_fields", {axi.arid, axi.araddr, axi.arlen} == '0, 1'b1);
    chk("rst_arsize", axi.arsize, 3'b010);
    chk("rst_arburst", axi.arburst, 2'b01);
    step();

    // Instruction refill, arready after two waiting cycles, clean 8-beat burst
    inst_addr = 32'h1FC0_0000; inst_len = 8'd7; inst_req = 1'b1;
    expect_grant(SIDE_INST, 0);
    serve(SIDE_INST, 32'h1FC0_0000, 8'd7, 2, -1, 1'b0, 1'b0);
    step();

    // Simultaneous requests; loser is granted in the first IDLE cycle
    inst_addr = 32'h0000_1000; inst_len = 8'd2;
    data_addr = 32'h8000_2000; data_len = 8'd1;
    inst_req = 1'b1; data_req = 1'b1;
    m_last_owner = SIDE_DATA;
    begin : conflict
      bit w;
      w = exp_winner();
      expect_grant(w, 0);
      serve(w, w ? 32'h8000_2000 : 32'h0000_1000, w ? 8'd1 : 8'd2, 0, -1, 1'b0, 1'b0);
      expect_grant(~w, 0);
      serve(~w, w ? 32'h0000_1000 : 32'h8000_2000, w ? 8'd2 : 8'd1, 1, -1, 1'b0, 1'b0);
    end
    step();

    // Flush masks an idle instruction request, then a flush after beat 1 drops beats 2-4
    inst_addr = 32'h0000_4000; inst_len = 8'd3; inst_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_mask_grant", inst_grant, 1'b0);
    step();
    flush = 1'b0;
    expect_grant(SIDE_INST, 0);
    serve(SIDE_INST, 32'h0000_4000, 8'd3, 0, 0, 1'b0, 1'b0);
    step();

    random_phase(30);

    // Early rlast on a data burst: sticky error, counter still defines the last beat
    data_addr = 32'h0000_8000; data_len = 8'd3; data_req = 1'b1;
    expect_grant(SIDE_DATA, 0);
    serve(SIDE_DATA, 32'h0000_8000, 8'd3, 0, -1, 1'b1, 1'b0);
    chk("perr_set", proto_err, 1'b1);
    inst_addr = 32'h0000_9000; inst_len = 8'd1; inst_req = 1'b1;
    expect_grant(SIDE_INST, 0);
    serve(SIDE_INST, 32'h0000_9000, 8'd1, 0, -1, 1'b0, 1'b0);
    chk("perr_sticky", proto_err, 1'b1);

    // Reset in the middle of a burst abandons it
    inst_addr = 32'h0000_A000; inst_len = 8'd7; inst_req = 1'b1;
    expect_grant(SIDE_INST, 0);
    axi.arready = 1'b1;
    @(negedge clk);
    step();
    axi.arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi.rvalid = 1'b1; axi.rdata = $urandom; axi.rid = INST_ID; axi.rlast = 1'b0;
      @(negedge clk);
      chk("pre_rst_rvalid", inst_rvalid, 1'b1);
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_rready", axi.rready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rvalid", inst_rvalid | data_rvalid, 1'b0);
    step();
    chk("mid_rst_rvalid2", inst_rvalid | data_rvalid, 1'b0);
    rst = 1'b0;
    axi.rvalid = 1'b0;
    m_perr = 1'b0;
    m_last_owner = SIDE_DATA;
    step();
    chk("post_rst_perr", proto_err, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    // Arbitration state after reset, then a burst with a wrong rid
    inst_addr = 32'h0000_B000; inst_len = 8'd0;
    data_addr = 32'h0000_C000; data_len = 8'd2;
    inst_req = 1'b1; data_req = 1'b1;
    begin : conflict2
      bit w;
      w = exp_winner();
      expect_grant(w, 0);
      serve(w, w ? 32'h0000_C000 : 32'h0000_B000, w ? 8'd2 : 8'd0, 0, -1, 1'b0, 1'b1);
      chk("rid_perr", proto_err, 1'b1);
      expect_grant(~w, 0);
      serve(~w, w ? 32'h0000_B000 : 32'h0000_C000, w ? 8'd0 : 8'd2, 0, -1, 1'b0, 1'b0);
    end

    random_phase(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
